// File: rtl/hack_cpu.sv
// Hack-architecture 16-bit CPU core: instruction decode, A/D/PC registers and the Hack ALU.
// Single-cycle: every instruction (A or C) retires on the rising edge that follows its fetch.
module hack_cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] inM,
    input  logic [15:0] instruction,
    output logic [15:0] outM,
    output logic [14:0] addressM,
    output logic [14:0] PC,
    output logic        writeM,
    output logic [6:0]  control_word
);

    typedef struct packed {
        logic       is_c;
        logic [1:0] spare;
        logic       a;
        logic       zx;
        logic       nx;
        logic       zy;
        logic       ny;
        logic       f;
        logic       no;
        logic       dest_a;
        logic       dest_d;
        logic       dest_m;
        logic       j_lt;
        logic       j_eq;
        logic       j_gt;
    } c_instr_t;

    c_instr_t    ci;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [14:0] pc_reg;

    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [15:0] alu_f;
    logic [15:0] alu_out;
    logic        zr;
    logic        ng;
    logic        jump;
    logic        unused_spare;

    assign ci           = c_instr_t'(instruction);
    assign unused_spare = ^ci.spare;

    // NOTE: every signal written in this block gets a value before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_x = d_reg;
        alu_y = ci.a ? inM : a_reg;
        if (ci.zx) alu_x = '0;
        if (ci.nx) alu_x = ~alu_x;
        if (ci.zy) alu_y = '0;
        if (ci.ny) alu_y = ~alu_y;
        alu_f   = ci.f ? (alu_x + alu_y) : (alu_x & alu_y);
        alu_out = ci.no ? ~alu_f : alu_f;
    end

    assign zr   = (alu_out == 16'h0000);
    assign ng   = alu_out[15];
    assign jump = ci.is_c & ((ci.j_lt & ng) | (ci.j_eq & zr) | (ci.j_gt & ~ng & ~zr));

    assign outM         = alu_out;
    assign addressM     = a_reg[14:0];
    assign PC           = pc_reg;
    assign writeM       = ci.is_c & ci.dest_m & ~reset;
    assign control_word = ci.is_c ? instruction[12:6] : 7'b0;

    // NOTE: non-blocking assignments make every register read its pre-edge value,
    // so a jump in the same cycle as an A load still targets the old A.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg  <= '0;
            d_reg  <= '0;
            pc_reg <= '0;
        end else begin
            if (!ci.is_c) begin
                a_reg <= instruction;
            end else if (ci.dest_a) begin
                a_reg <= alu_out;
            end
            if (ci.is_c && ci.dest_d) begin
                d_reg <= alu_out;
            end
            pc_reg <= jump ? a_reg[14:0] : pc_reg + 15'd1;
        end
    end

endmodule

// File: tb/tb_hack_cpu.sv
// Directed self-checking bench for hack_cpu; A and D are observed through addressM/outM
// by presenting "A" (0xEC00) and "D" (0xE300) compute instructions.
module tb_hack_cpu;

    logic        clk;
    logic        reset;
    logic [15:0] in_m;
    logic [15:0] instruction;
    logic [15:0] out_m;
    logic [14:0] address_m;
    logic [14:0] pc;
    logic        write_m;
    logic [6:0]  control_word;

    int errors = 0;
    int checks = 0;

    localparam logic [15:0] I_SHOW_D = 16'hE300;  // D
    localparam logic [15:0] I_SHOW_A = 16'hEC00;  // A

    hack_cpu dut (
        .clk         (clk),
        .reset       (reset),
        .inM         (in_m),
        .instruction (instruction),
        .outM        (out_m),
        .addressM    (address_m),
        .PC          (pc),
        .writeM      (write_m),
        .control_word(control_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after
    // presenting, well away from the next edge.
    task automatic present(input logic [15:0] instr, input logic [15:0] m);
        instruction = instr;
        in_m        = m;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exec(input logic [15:0] instr, input logic [15:0] m);
        present(instr, m);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        present(16'h0000, 16'h0000);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        present(16'hE308, 16'h0000);
        tick();
        tick();
        checks++;
        if (pc !== 15'h0000) begin
            errors++; $display("FAIL reset_pc: got %h want %h", pc, 15'h0000);
        end
        checks++;
        if (address_m !== 15'h0000) begin
            errors++; $display("FAIL reset_addr: got %h want %h", address_m, 15'h0000);
        end
        checks++;
        if (write_m !== 1'b0) begin
            errors++; $display("FAIL reset_writem: got %b want 0", write_m);
        end
        reset = 1'b0;
        exec(16'h0000, 16'h0000);
        checks++;
        if (pc !== 15'h0001) begin
            errors++; $display("FAIL release_pc1: got %h want %h", pc, 15'h0001);
        end
        exec(16'h0000, 16'h0000);
        checks++;
        if (pc !== 15'h0002) begin
            errors++; $display("FAIL release_pc2: got %h want %h", pc, 15'h0002);
        end
    endtask

    task automatic test_a_d_write();
        do_reset();
        present(16'h0005, 16'h0000);
        checks++;
        if (write_m !== 1'b0 || control_word !== 7'b0) begin
            errors++; $display("FAIL ainstr_decode: writeM=%b cw=%b want 0/0000000", write_m, control_word);
        end
        tick();
        exec(16'hEC10, 16'h0000);
        checks++;
        if (pc !== 15'h0002 || address_m !== 15'h0005) begin
            errors++; $display("FAIL d_eq_a: pc=%h addr=%h want 0002/0005", pc, address_m);
        end
        present(16'hE308, 16'h0000);
        checks++;
        if (write_m !== 1'b1 || address_m !== 15'h0005 || out_m !== 16'h0005) begin
            errors++; $display("FAIL m_eq_d: writeM=%b addr=%h outM=%h want 1/0005/0005", write_m, address_m, out_m);
        end
        checks++;
        if (control_word !== 7'b0001100) begin
            errors++; $display("FAIL m_eq_d_cw: got %b want 0001100", control_word);
        end
        tick();
    endtask

    task automatic test_alu_m();
        do_reset();
        exec(16'h0002, 16'h0000);
        exec(16'hEC10, 16'h0000);
        exec(16'h0003, 16'h0000);
        present(16'hF090, 16'h0007);
        checks++;
        if (control_word !== 7'b1000010) begin
            errors++; $display("FAIL dpm_cw: got %b want 1000010", control_word);
        end
        tick();
        present(I_SHOW_D, 16'h0000);
        checks++;
        if (out_m !== 16'h0009) begin
            errors++; $display("FAIL d_plus_m: D=%h want 0009", out_m);
        end
        tick();
        exec(16'hE390, 16'h0000);
        present(I_SHOW_D, 16'h0000);
        checks++;
        if (out_m !== 16'h0008) begin
            errors++; $display("FAIL d_minus_1: D=%h want 0008", out_m);
        end
        tick();
    endtask

    task automatic test_jumps();
        do_reset();
        exec(16'h0010, 16'h0000);   // PC 1
        exec(16'hEA90, 16'h0000);   // D=0, PC 2
        exec(16'hE302, 16'h0000);   // D;JEQ taken
        checks++;
        if (pc !== 15'h0010) begin
            errors++; $display("FAIL jeq_taken: pc=%h want 0010", pc);
        end
        exec(16'hEFD0, 16'h0000);   // D=1, PC 11
        exec(16'hE302, 16'h0000);   // D;JEQ not taken
        checks++;
        if (pc !== 15'h0012) begin
            errors++; $display("FAIL jeq_not_taken: pc=%h want 0012", pc);
        end
        exec(16'hEE90, 16'h0000);   // D=-1, PC 13
        exec(16'hE301, 16'h0000);   // D;JGT not taken on negative
        checks++;
        if (pc !== 15'h0014) begin
            errors++; $display("FAIL jgt_neg: pc=%h want 0014", pc);
        end
        exec(16'hE304, 16'h0000);   // D;JLT taken
        checks++;
        if (pc !== 15'h0010) begin
            errors++; $display("FAIL jlt_taken: pc=%h want 0010", pc);
        end
        exec(16'hEFD0, 16'h0000);   // PC 11
        present(16'hEA87, 16'h0000);
        checks++;
        if (write_m !== 1'b0) begin
            errors++; $display("FAIL jmp_writem: got %b want 0", write_m);
        end
        tick();
        checks++;
        if (pc !== 15'h0010) begin
            errors++; $display("FAIL jmp_uncond: pc=%h want 0010", pc);
        end
        exec(16'hEA90, 16'h0000);   // D=0, PC 11
        exec(16'hE322, 16'h0000);   // A=D;JEQ: jump to old A, A becomes 0
        checks++;
        if (pc !== 15'h0010 || address_m !== 15'h0000) begin
            errors++; $display("FAIL d1_and_jump: pc=%h addr=%h want 0010/0000", pc, address_m);
        end
    endtask

    task automatic test_am_inc();
        do_reset();
        exec(16'h0004, 16'h0000);
        present(16'hFDE8, 16'h7FFF);
        checks++;
        if (out_m !== 16'h8000 || write_m !== 1'b1 || address_m !== 15'h0004) begin
            errors++; $display("FAIL am_m_plus_1: outM=%h writeM=%b addr=%h want 8000/1/0004", out_m, write_m, address_m);
        end
        tick();
        checks++;
        if (address_m !== 15'h0000) begin
            errors++; $display("FAIL am_next_addr: got %h want 0000", address_m);
        end
        present(I_SHOW_A, 16'h0000);
        checks++;
        if (out_m !== 16'h8000) begin
            errors++; $display("FAIL am_full_a: A=%h want 8000", out_m);
        end
        tick();
    endtask

    task automatic test_pc_wrap_and_midreset();
        do_reset();
        exec(16'h7FFF, 16'h0000);
        exec(16'hEA87, 16'h0000);
        checks++;
        if (pc !== 15'h7FFF) begin
            errors++; $display("FAIL wrap_setup: pc=%h want 7fff", pc);
        end
        exec(I_SHOW_D, 16'h0000);
        checks++;
        if (pc !== 15'h0000) begin
            errors++; $display("FAIL pc_wrap: pc=%h want 0000", pc);
        end
        exec(16'h1234, 16'h0000);
        exec(16'hEC10, 16'h0000);   // A=D=0x1234
        reset = 1'b1;
        present(16'hE308, 16'h0000);
        checks++;
        if (write_m !== 1'b0) begin
            errors++; $display("FAIL midreset_writem: got %b want 0", write_m);
        end
        tick();
        reset = 1'b0;
        checks++;
        if (pc !== 15'h0000 || address_m !== 15'h0000) begin
            errors++; $display("FAIL midreset_pc_a: pc=%h addr=%h want 0000/0000", pc, address_m);
        end
        present(I_SHOW_D, 16'h0000);
        checks++;
        if (out_m !== 16'h0000) begin
            errors++; $display("FAIL midreset_d: D=%h want 0000", out_m);
        end
        present(I_SHOW_A, 16'h0000);
        checks++;
        if (out_m !== 16'h0000) begin
            errors++; $display("FAIL midreset_a: A=%h want 0000", out_m);
        end
    endtask

    initial begin
        reset       = 1'b1;
        instruction = 16'h0000;
        in_m        = 16'h0000;
        #1;
        test_reset();
        test_a_d_write();
        test_alu_m();
        test_jumps();
        test_am_inc();
        test_pc_wrap_and_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
